// File: rtl/fnd_scan_controller.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous shadow update.
// Optional leading-zero blanking is built when FND_LZB_EN is defined.
module fnd_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic [7:0]              o_font,
  output logic                    o_frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit INV   = (ACTIVE_LOW != 0);

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            FONT_OFF  = INV ? 8'hFF : 8'h00;

  // Segment pattern {g,f,e,d,c,b,a}, 1 = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      4'hF:    hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  logic [PRE_W-1:0]        pre_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] stage_val_r;
  logic [NUM_DIGITS-1:0]   stage_dp_r;
  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] shadow_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [NUM_DIGITS-1:0]   digit_r;
  logic [7:0]              font_r;
  logic                    frame_tick_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    dp_s;
  logic                    blank_s;
  logic [7:0]              font_hi_s;
  logic [NUM_DIGITS-1:0]   digit_hi_s;

  assign tick_s = i_en & (pre_r == PRE_LAST);
  assign wrap_s = tick_s & (idx_r == IDX_LAST);

`ifdef FND_LZB_EN
  logic [NUM_DIGITS-1:0] blank_mask_s;

  // Leading-zero mask: stays set from the top digit down until a non-zero nibble or lit dp.
  always_comb begin
    logic lead;
    lead = 1'b1;
    blank_mask_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead & (shadow_val_r[4*i +: 4] == 4'h0) & ~shadow_dp_r[i];
      blank_mask_s[i] = lead;
    end
  end

  assign blank_s = blank_mask_s[idx_r];
`else
  assign blank_s = 1'b0;
`endif

  // Select the current digit's nibble/dp and build active-high font and select.
  always_comb begin
    nib_s      = shadow_val_r[4*int'(idx_r) +: 4];
    dp_s       = shadow_dp_r[idx_r];
    digit_hi_s = DIGIT_ONE << idx_r;
    if (blank_s) begin
      font_hi_s = 8'h00;
    end else begin
      font_hi_s = {dp_s, hex_to_seg(nib_s)};
    end
  end

  // Prescaler, scan index, staging/shadow handshake and registered pin outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_r        <= {PRE_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      stage_val_r  <= {(4*NUM_DIGITS){1'b0}};
      stage_dp_r   <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      digit_r      <= DIGIT_OFF;
      font_r       <= FONT_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      if (i_load) begin
        stage_val_r <= i_value;
        stage_dp_r  <= i_dp;
      end
      // A load on the commit edge keeps pending set for the following frame.
      pending_r <= i_load | (pending_r & ~wrap_s);
      if (wrap_s && pending_r) begin
        shadow_val_r <= stage_val_r;
        shadow_dp_r  <= stage_dp_r;
      end

      if (!i_en) begin
        pre_r        <= {PRE_W{1'b0}};
        idx_r        <= {IDX_W{1'b0}};
        digit_r      <= DIGIT_OFF;
        font_r       <= FONT_OFF;
        frame_tick_r <= 1'b0;
      end else begin
        if (tick_s) begin
          pre_r <= {PRE_W{1'b0}};
          idx_r <= wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
          pre_r <= pre_r + PRE_W'(1);
        end
        digit_r      <= INV ? ~digit_hi_s : digit_hi_s;
        font_r       <= INV ? ~font_hi_s : font_hi_s;
        frame_tick_r <= wrap_s;
      end
    end
  end

  assign o_digit      = digit_r;
  assign o_font       = font_r;
  assign o_frame_tick = frame_tick_r;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: 4 digits, DIV=4, common-anode and inverted builds side by side.
module tb_fnd_scan_controller;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  digit;
  logic [7:0]  font;
  logic        ftick;
  logic [3:0]  digit_hi;
  logic [7:0]  font_hi;
  logic        ftick_hi;

  int errors = 0;
  int checks = 0;
  logic [7:0] z;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] fonts;  // {digit3, digit2, digit1, digit0}, common-anode codes
  } vec_t;

  vec_t vecs[8];

  fnd_scan_controller #(
    .NUM_DIGITS(4), .CLK_HZ(8), .SCAN_HZ(2), .ACTIVE_LOW(1)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_value(value), .i_dp(dp), .i_load(load),
    .o_digit(digit), .o_font(font), .o_frame_tick(ftick)
  );

  fnd_scan_controller #(
    .NUM_DIGITS(4), .CLK_HZ(8), .SCAN_HZ(2), .ACTIVE_LOW(0)
  ) u_dut_hi (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_value(value), .i_dp(dp), .i_load(load),
    .o_digit(digit_hi), .o_font(font_hi), .o_frame_tick(ftick_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_off(input string name);
    chk({name, "_digit"}, {4'h0, digit}, 8'h0F);
    chk({name, "_font"}, font, 8'hFF);
    chk({name, "_tick"}, {7'h0, ftick}, 8'h00);
    chk({name, "_digit_hi"}, {4'h0, digit_hi}, 8'h00);
    chk({name, "_font_hi"}, font_hi, 8'h00);
  endtask

  task automatic wait_frame_tick(input string name);
    int n;
    n = 0;
    step();
    while (!ftick && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!ftick) begin
      errors++;
      $display("FAIL %s: frame tick not seen within %0d cycles", name, n);
    end
  endtask

  // Expects to start right after a frame tick; steps through one full 16-cycle frame.
  task automatic check_frame(input logic [31:0] fonts, input string name);
    logic [3:0] oh;
    logic [7:0] ef;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        oh = 4'b0001 << d;
        ef = fonts[8*d +: 8];
        chk({name, "_digit"}, {4'h0, digit}, {4'h0, ~oh});
        chk({name, "_font"}, font, ef);
        chk({name, "_digit_hi"}, {4'h0, digit_hi}, {4'h0, oh});
        chk({name, "_font_hi"}, font_hi, ~ef);
        chk({name, "_tick"}, {7'h0, ftick}, {7'h0, (d == 3 && k == 3)});
      end
    end
  endtask

  initial begin
`ifdef FND_LZB_EN
    z = 8'hFF;
`else
    z = 8'hC0;
`endif
    vecs[0] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h0005, 4'b0010, {z, z, 8'h40, 8'h92}};
    vecs[2] = '{16'h0005, 4'b0000, {z, z, z, 8'h92}};
    vecs[3] = '{16'h0008, 4'b0000, {z, z, z, 8'h80}};
    vecs[4] = '{16'hABCD, 4'b1111, {8'h08, 8'h03, 8'h46, 8'h21}};
    vecs[5] = '{16'h6F70, 4'b0000, {8'h82, 8'h8E, 8'hF8, 8'hC0}};
    vecs[6] = '{16'h0000, 4'b0000, {z, z, z, 8'hC0}};
    vecs[7] = '{16'h9E00, 4'b0000, {8'h90, 8'h86, 8'hC0, 8'hC0}};

    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0000; dp = 4'h0;
    step();
    step();
    check_off("reset");

    rst = 1'b0;
    en  = 1'b1;
    wait_frame_tick("first_frame");

    for (int i = 0; i < 8; i++) begin
      value = vecs[i].value;
      dp    = vecs[i].dp;
      load  = 1'b1;
      step();
      load  = 1'b0;
      dp    = 4'h0;
      wait_frame_tick("vec_commit");
      check_frame(vecs[i].fonts, "vec");
    end

    // Two mid-frame loads: last one wins, old frame completes untouched.
    repeat (5) step();
    value = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame_tick("last_wins_commit");
    chk("no_tear_font", font, 8'h90);
    chk("no_tear_digit", {4'h0, digit}, 8'h07);
    check_frame({4{8'hA4}}, "last_wins");

    // Load on the commit edge: older staging commits, new one stays pending.
    value = 16'h4444; load = 1'b1;
    step();
    load = 1'b0;
    repeat (14) step();
    value = 16'h3333; load = 1'b1;
    step();
    load = 1'b0;
    chk("coincident_tick", {7'h0, ftick}, 8'h01);
    check_frame({4{8'h99}}, "coincident_old");
    check_frame({4{8'hB0}}, "coincident_new");

    // Disable mid-frame, load while disabled, then restart from digit 0 with a full period.
    repeat (6) step();
    en = 1'b0;
    step();
    check_off("disable");
    value = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check_off("disable_hold");
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("restart_digit0", {4'h0, digit}, 8'h0E);
      chk("restart_font0", font, 8'hB0);
    end
    step();
    chk("restart_digit1", {4'h0, digit}, 8'h0D);
    wait_frame_tick("disabled_load_commit");
    check_frame({4{8'h92}}, "disabled_load");

    // Reset mid-frame discards staged data and clears the shadow.
    value = 16'h7777; load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_off("reset_mid");
    rst = 1'b0;
    wait_frame_tick("after_reset");
    check_frame({z, z, z, 8'hC0}, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
